// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset constants and helpers shared by the CLINT blocks
package clint_pkg;

    localparam logic [15:0] MSIP        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE, REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_TIME_LO, REG_TIME_HI
    } reg_e;

    function automatic reg_e decode(input logic [15:0] off);
        return off == MSIP        ? REG_MSIP    :
               off == MTIMECMP_LO ? REG_CMP_LO  :
               off == MTIMECMP_HI ? REG_CMP_HI  :
               off == MTIME_LO    ? REG_TIME_LO :
               off == MTIME_HI    ? REG_TIME_HI : REG_NONE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: tick prescaler, 64-bit mtime counter with per-half byte writes, and
// the registered mtime >= mtimecmp comparator
module clint_timer
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_sel,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtime,
    output logic        mtip
);

    logic [15:0] pre;
    logic        tick;

    assign tick = pre == 16'(TICK_DIV - 1);

    // A software write to either half overrides that cycle's increment entirely
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre   <= '0;
            mtime <= '0;
            mtip  <= 1'b0;
        end else begin
            pre   <= tick ? '0 : pre + 16'd1;
            mtip  <= mtime >= mtimecmp;
            mtime <= wr_lo ? {mtime[63:32], merge(mtime[31:0], wr_data, wr_sel)} :
                     wr_hi ? {merge(mtime[63:32], wr_data, wr_sel), mtime[31:0]} :
                     mtime + 64'(tick);
        end
    end

endmodule

// File: rtl/wb_clint.sv
// wb_clint: Wishbone-attached RISC-V core-local interruptor (msip, mtimecmp, mtime)
// with single-cycle response latency and bus error on unmapped or misaligned access
module wb_clint
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    logic [31:0] off;
    reg_e        reg_sel;
    logic        accept;
    logic        valid;
    logic        wr;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [31:0] rdata;

    assign off     = wbs_addr_i - BASE_ADDR;
    assign reg_sel = (off[31:16] != '0 || wbs_addr_i[1:0] != 2'b00) ? REG_NONE : decode(off[15:0]);
    assign valid   = reg_sel != REG_NONE;
    assign accept  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign wr      = accept & valid & wbs_we_i & (|wbs_sel_i);

    assign rdata = reg_sel == REG_MSIP    ? {31'b0, msip}   :
                   reg_sel == REG_CMP_LO  ? mtimecmp[31:0]  :
                   reg_sel == REG_CMP_HI  ? mtimecmp[63:32] :
                   reg_sel == REG_TIME_LO ? mtime[31:0]     :
                   reg_sel == REG_TIME_HI ? mtime[63:32]    : '0;

    clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_lo    (wr && reg_sel == REG_TIME_LO),
        .wr_hi    (wr && reg_sel == REG_TIME_HI),
        .wr_data  (wbs_dat_i),
        .wr_sel   (wbs_sel_i),
        .mtimecmp (mtimecmp),
        .mtime    (mtime),
        .mtip     (xint_mtip_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            msip      <= 1'b0;
            mtimecmp  <= MTIMECMP_RST;
        end else begin
            wbs_ack_o <= accept & valid;
            wbs_err_o <= accept & ~valid;
            wbs_dat_o <= (accept && valid && !wbs_we_i) ? rdata : '0;
            if (wr && reg_sel == REG_MSIP && wbs_sel_i[0])
                msip <= wbs_dat_i[0];
            if (wr && reg_sel == REG_CMP_LO)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
            if (wr && reg_sel == REG_CMP_HI)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
        end
    end

    assign xint_msip_o = msip;

endmodule

// File: tb/tb_wb_clint.sv
// tb_wb_clint: drives a TICK_DIV=1 and a TICK_DIV=4 CLINT from one bus and checks both
// against a cycle-level reference model of the register file and timer
module tb_wb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int DIVS[2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [31:0] dat1, dat4;
    logic        ack1, ack4, err1, err4, mtip1, mtip4, msip1, msip4;

    logic [31:0] o_dat[2];
    logic        o_ack[2], o_err[2], o_mtip[2], o_msip[2];
    assign o_dat[0] = dat1;   assign o_dat[1] = dat4;
    assign o_ack[0] = ack1;   assign o_ack[1] = ack4;
    assign o_err[0] = err1;   assign o_err[1] = err4;
    assign o_mtip[0] = mtip1; assign o_mtip[1] = mtip4;
    assign o_msip[0] = msip1; assign o_msip[1] = msip4;

    logic [63:0] m_time[2], m_cmp[2];
    logic [31:0] m_dat[2];
    bit          m_ack[2], m_err[2], m_mtip[2], m_msip[2];
    int          m_cyc = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    wb_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) u1 (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat1),
        .wbs_ack_o(ack1), .wbs_err_o(err1), .xint_mtip_o(mtip1), .xint_msip_o(msip1));

    wb_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) u4 (
        .clk_i(clk), .rst_i(rst), .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_dat_o(dat4),
        .wbs_ack_o(ack4), .wbs_err_o(err4), .xint_mtip_o(mtip4), .xint_msip_o(msip4));

    function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
        return {s[3] ? d[31:24] : old[31:24], s[2] ? d[23:16] : old[23:16],
                s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
    endfunction

    // One clock edge: the model consumes the inputs the DUTs saw, then outputs settle
    task automatic cycle();
        logic [31:0] o, rd;
        logic [15:0] lo16;
        logic [63:0] t, c;
        bit          ok, acc, tick;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            o    = addr - BASE;
            lo16 = o[15:0];
            ok   = o[31:16] == 16'h0 && addr[1:0] == 2'b00 &&
                   (lo16 inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
            acc  = cyc && stb && !m_ack[k] && !m_err[k];
            tick = ((m_cyc + 1) % DIVS[k]) == 0;
            t    = m_time[k];
            c    = m_cmp[k];
            rd   = lo16 == 16'h0000 ? {31'b0, m_msip[k]} : lo16 == 16'h4000 ? c[31:0] :
                   lo16 == 16'h4004 ? c[63:32] : lo16 == 16'hBFF8 ? t[31:0] : t[63:32];
            if (rst) begin
                m_time[k] = 64'd0; m_cmp[k] = {64{1'b1}}; m_msip[k] = 0; m_mtip[k] = 0;
                m_ack[k] = 0; m_err[k] = 0; m_dat[k] = 32'd0;
            end else begin
                m_mtip[k] = t >= c;
                m_time[k] = t + 64'(tick);
                m_ack[k]  = acc && ok;
                m_err[k]  = acc && !ok;
                m_dat[k]  = (acc && ok && !we) ? rd : 32'd0;
                if (acc && ok && we && sel != 4'h0) begin
                    if (lo16 == 16'h0000 && sel[0]) m_msip[k] = wdat[0];
                    if (lo16 == 16'h4000) m_cmp[k][31:0]  = bytes_in(c[31:0], wdat, sel);
                    if (lo16 == 16'h4004) m_cmp[k][63:32] = bytes_in(c[63:32], wdat, sel);
                    if (lo16 == 16'hBFF8) m_time[k] = {t[63:32], bytes_in(t[31:0], wdat, sel)};
                    if (lo16 == 16'hBFFC) m_time[k] = {bytes_in(t[63:32], wdat, sel), t[31:0]};
                end
            end
        end
        m_cyc = rst ? 0 : m_cyc + 1;
        #1;
    endtask

    // Holds the request until a response appears; returns with the response visible
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        int n = 0;
        cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s;
        do begin
            cycle();
            n++;
        end while (!(o_ack[0] || o_err[0]) && n < 4);
        cyc = 0; stb = 0; we = 0;
        if (!(o_ack[0] || o_err[0])) begin
            total++; bad++;
            $display("FAIL bus_timeout addr=%h got no response within 4 cycles", a);
        end
    endtask

    task automatic do_reset();
        rst = 1; cycle(); cycle(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_ack[k], o_err[k], o_mtip[k], o_msip[k]} !== 4'b0 || o_dat[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset[%0d] got ack/err/mtip/msip=%b%b%b%b dat=%h want 0000 0",
                         k, o_ack[k], o_err[k], o_mtip[k], o_msip[k], o_dat[k]);
            end
        end
    endtask

    task automatic test_idle();
        repeat (100) cycle();
        bus(0, BASE + 32'hBFF8, 0, 4'hF);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_dat[k] !== m_dat[k] || o_ack[k] !== 1'b1) begin
                bad++;
                $display("FAIL idle_mtime[%0d] got %h ack=%b want %h ack=1", k, o_dat[k], o_ack[k], m_dat[k]);
            end
        end
        total++;
        if (o_mtip[0] !== 1'b0) begin bad++; $display("FAIL idle_mtip got %b want 0", o_mtip[0]); end
    endtask

    task automatic test_mtip();
        bit found = 0;
        do_reset();
        bus(1, BASE + 32'h4004, 32'h0, 4'hF);
        bus(1, BASE + 32'h4000, 32'd50, 4'hF);
        for (int n = 0; n < 80 && !found; n++) begin
            cycle();
            found = m_time[0] == 64'd50;
        end
        total++;
        if (!found || o_mtip[0] !== 1'b0) begin
            bad++; $display("FAIL mtip_at50 found=%0d got %b want 0", found, o_mtip[0]);
        end
        cycle();
        total++;
        if (o_mtip[0] !== 1'b1) begin bad++; $display("FAIL mtip_rise got %b want 1", o_mtip[0]); end
        bus(1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
        total++;
        if (o_mtip[0] !== 1'b1) begin bad++; $display("FAIL mtip_hold got %b want 1", o_mtip[0]); end
        cycle();
        total++;
        if (o_mtip[0] !== 1'b0) begin bad++; $display("FAIL mtip_clear got %b want 0", o_mtip[0]); end
        total++;
        if (o_mtip[1] !== m_mtip[1]) begin bad++; $display("FAIL mtip_div4 got %b want %b", o_mtip[1], m_mtip[1]); end
    endtask

    task automatic test_carry();
        do_reset();
        bus(1, BASE + 32'hBFFC, 32'h0, 4'hF);
        bus(1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(0, BASE + 32'hBFFC, 0, 4'hF);
        total++;
        if (o_dat[0] !== 32'h1) begin bad++; $display("FAIL carry_hi got %h want 00000001", o_dat[0]); end
        total++;
        if (o_dat[1] !== m_dat[1]) begin bad++; $display("FAIL carry_hi_div4 got %h want %h", o_dat[1], m_dat[1]); end
        bus(1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        bus(1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(0, BASE + 32'hBFFC, 0, 4'hF);
        total++;
        if (o_dat[0] !== 32'h0) begin bad++; $display("FAIL wrap_hi got %h want 00000000", o_dat[0]); end
        bus(0, BASE + 32'hBFF8, 0, 4'hF);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (o_dat[k] !== m_dat[k]) begin bad++; $display("FAIL wrap_lo[%0d] got %h want %h", k, o_dat[k], m_dat[k]); end
        end
    endtask

    task automatic test_msip();
        bus(1, BASE, 32'h1, 4'b0001);
        total++;
        if (o_msip[0] !== 1'b1 || o_msip[1] !== 1'b1) begin bad++; $display("FAIL msip_set got %b%b want 11", o_msip[0], o_msip[1]); end
        bus(1, BASE, 32'h0, 4'b0010);
        total++;
        if (o_msip[0] !== 1'b1) begin bad++; $display("FAIL msip_lane got %b want 1", o_msip[0]); end
        bus(0, BASE, 0, 4'hF);
        total++;
        if (o_dat[0] !== 32'h1) begin bad++; $display("FAIL msip_read got %h want 00000001", o_dat[0]); end
        bus(1, BASE, 32'h0, 4'b0001);
        total++;
        if (o_msip[0] !== 1'b0) begin bad++; $display("FAIL msip_clr got %b want 0", o_msip[0]); end
        bus(1, BASE + 32'h4000, 32'h1234, 4'b0000);
        total++;
        if (o_ack[0] !== 1'b1 || o_err[0] !== 1'b0) begin bad++; $display("FAIL sel0_ack got ack=%b err=%b want 1 0", o_ack[0], o_err[0]); end
        bus(0, BASE + 32'h4000, 0, 4'hF);
        total++;
        if (o_dat[0] !== m_dat[0]) begin bad++; $display("FAIL sel0_nochange got %h want %h", o_dat[0], m_dat[0]); end
    endtask

    task automatic test_err();
        logic [31:0] offs[4] = '{32'h0008, 32'h4002, 32'h0001_0000, 32'hFFFF_FFFC};
        for (int i = 0; i < 4; i++) begin
            bus(1, BASE + offs[i], 32'h0, 4'hF);
            total++;
            if (o_err[0] !== 1'b1 || o_ack[0] !== 1'b0 || o_dat[0] !== 32'h0) begin
                bad++; $display("FAIL err_%h got err=%b ack=%b dat=%h want 1 0 0", offs[i], o_err[0], o_ack[0], o_dat[0]);
            end
            cycle();
            total++;
            if (o_err[0] !== 1'b0) begin bad++; $display("FAIL err_pulse_%h got %b want 0", offs[i], o_err[0]); end
        end
        bus(0, BASE + 32'h4000, 0, 4'hF);
        total++;
        if (o_dat[0] !== m_dat[0]) begin bad++; $display("FAIL err_cmp_lo got %h want %h", o_dat[0], m_dat[0]); end
        bus(0, BASE + 32'h4004, 0, 4'hF);
        total++;
        if (o_dat[0] !== m_dat[0]) begin bad++; $display("FAIL err_cmp_hi got %h want %h", o_dat[0], m_dat[0]); end
    endtask

    task automatic test_tick_write();
        logic [31:0] want[3] = '{32'h10, 32'h10, 32'h11};
        cycle();
        while (((m_cyc + 1) % 4) != 0) cycle();
        bus(1, BASE + 32'hBFF8, 32'h10, 4'hF);
        for (int i = 0; i < 3; i++) begin
            bus(0, BASE + 32'hBFF8, 0, 4'hF);
            total++;
            if (o_dat[1] !== want[i]) begin bad++; $display("FAIL tickwr_%0d got %h want %h", i, o_dat[1], want[i]); end
            total++;
            if (o_dat[0] !== m_dat[0]) begin bad++; $display("FAIL tickwr_div1_%0d got %h want %h", i, o_dat[0], m_dat[0]); end
        end
    endtask

    task automatic test_reset_mid();
        cyc = 1; stb = 1; we = 1; addr = BASE + 32'h4000; wdat = 32'h5; sel = 4'hF; rst = 1;
        cycle();
        rst = 0; cyc = 0; stb = 0; we = 0;
        total++;
        if (o_ack[0] !== 1'b0 || o_err[0] !== 1'b0) begin bad++; $display("FAIL rst_same got ack=%b err=%b want 0 0", o_ack[0], o_err[0]); end
        cyc = 1; stb = 1; we = 1; wdat = 32'h7;
        cycle();
        rst = 1; cyc = 0; stb = 0; we = 0;
        cycle();
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_ack[k], o_err[k], o_mtip[k], o_msip[k]} !== 4'b0) begin
                bad++; $display("FAIL rst_pending[%0d] got ack/err/mtip/msip=%b%b%b%b want 0000", k, o_ack[k], o_err[k], o_mtip[k], o_msip[k]);
            end
        end
        bus(0, BASE + 32'h4000, 0, 4'hF);
        total++;
        if (o_dat[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo got %h want ffffffff", o_dat[0]); end
        bus(0, BASE + 32'h4004, 0, 4'hF);
        total++;
        if (o_dat[1] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi got %h want ffffffff", o_dat[1]); end
        bus(0, BASE + 32'hBFFC, 0, 4'hF);
        total++;
        if (o_dat[0] !== 32'h0) begin bad++; $display("FAIL rst_time_hi got %h want 00000000", o_dat[0]); end
    endtask

    task automatic test_random();
        logic [31:0] offs[10] = '{32'h0, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC,
                                  32'h8, 32'h4002, 32'hBFFA, 32'h0001_0000, 32'hFFFF_FFFC};
        logic [31:0] d;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                cycle();
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (o_mtip[k] !== m_mtip[k]) begin bad++; $display("FAIL rnd_idle_mtip[%0d] i=%0d got %b want %b", k, i, o_mtip[k], m_mtip[k]); end
                end
            end
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
            bus($urandom_range(0, 1) == 1, BASE + offs[$urandom_range(0, 9)], d, 4'($urandom_range(0, 15)));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_ack[k] !== m_ack[k] || o_err[k] !== m_err[k] || o_dat[k] !== m_dat[k] ||
                    o_mtip[k] !== m_mtip[k] || o_msip[k] !== m_msip[k]) begin
                    bad++;
                    $display("FAIL rnd[%0d] i=%0d addr=%h got ack=%b err=%b dat=%h mtip=%b msip=%b want %b %b %h %b %b",
                             k, i, addr, o_ack[k], o_err[k], o_dat[k], o_mtip[k], o_msip[k],
                             m_ack[k], m_err[k], m_dat[k], m_mtip[k], m_msip[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
        test_reset();
        test_idle();
        test_mtip();
        test_carry();
        test_msip();
        test_err();
        test_tick_write();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
